// File: rtl/inst_sram_axi.sv
// Instruction SRAM behind a minimal AXI-style read channel (AR/R only).
// One outstanding fetch at a time, fixed read latency, plus a side-band preload write port.
module inst_sram_axi #(
  parameter int                  DATA_LEN   = 32,
  parameter logic [DATA_LEN-1:0] ADDR_BASE  = 32'h8000_0000,
  parameter int                  DEPTH_LOG2 = 10,
  parameter int                  RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [DATA_LEN-1:0]   araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_LEN-1:0]   rdata,
  output logic [2:0]            rresp,
  input  logic                  wen,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_LEN-1:0]   wdata
);

  localparam int                WORDS       = 1 << DEPTH_LOG2;
  localparam logic [DATA_LEN:0] SPAN_BYTES  = (DATA_LEN+1)'(4 * WORDS);
  localparam logic [7:0]        LAT_LOAD    = 8'(RD_LAT - 1);
  localparam logic [2:0]        RESP_OKAY   = 3'b000;
  localparam logic [2:0]        RESP_SLVERR = 3'b010;
  localparam logic [2:0]        RESP_DECERR = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_LEN-1:0]   rdata_q, rdata_d;
  logic [2:0]            rresp_q, rresp_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_LEN-1:0]   addr_q, addr_d;

  logic [DATA_LEN-1:0]   mem [WORDS];
  logic [DATA_LEN-1:0]   off_w;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DATA_LEN-1:0]   rd_word;
  logic [2:0]            resp_w;

  // Offset wraps below the base, so one unsigned compare covers both range ends;
  // decode error outranks the misalignment error.
  function automatic logic [2:0] decode_resp(input logic [DATA_LEN-1:0] off);
    if ({1'b0, off} >= SPAN_BYTES) return RESP_DECERR;
    if (off[1:0] != 2'b00)         return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  assign off_w   = addr_q - ADDR_BASE;
  assign rd_idx  = off_w[DEPTH_LOG2+1:2];
  assign rd_word = mem[rd_idx];
  assign resp_w  = decode_resp(off_w);

  // Preload port is independent of reset and FSM state; the nonblocking write
  // gives read-before-write when it collides with the response sample.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          addr_d    = araddr;
          cnt_d     = LAT_LOAD;
          arready_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          rvalid_d = 1'b1;
          rresp_d  = resp_w;
          rdata_d  = (resp_w == RESP_OKAY) ? rd_word : '0;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rdata_d   = '0;
        rresp_d   = RESP_OKAY;
        cnt_d     = 8'd0;
        addr_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      cnt_q     <= 8'd0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_inst_sram_axi.sv
// Randomized bench for inst_sram_axi against a transaction-level memory model.
module tb_inst_sram_axi;

  localparam int          DL    = 32;
  localparam int          DL2   = 10;
  localparam int          LAT   = 2;
  localparam int          WORDS = 1 << DL2;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic          clk;
  logic          rst_n;
  logic          arvalid;
  logic          arready;
  logic [DL-1:0] araddr;
  logic          rvalid;
  logic          rready;
  logic [DL-1:0] rdata;
  logic [2:0]    rresp;
  logic          wen;
  logic [DL2-1:0] waddr;
  logic [DL-1:0] wdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] ref_mem [WORDS];

  inst_sram_axi #(
    .DATA_LEN  (DL),
    .ADDR_BASE (BASE),
    .DEPTH_LOG2(DL2),
    .RD_LAT    (LAT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arvalid(arvalid),
    .arready(arready),
    .araddr (araddr),
    .rvalid (rvalid),
    .rready (rready),
    .rdata  (rdata),
    .rresp  (rresp),
    .wen    (wen),
    .waddr  (waddr),
    .wdata  (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] model_resp(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || off >= 4 * WORDS) return 3'b011;
    if (a % 4 != 0) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] a);
    longint off;
    if (model_resp(a) != 3'b000) return 32'h0;
    off = longint'(a) - longint'(BASE);
    return ref_mem[int'(off / 4)];
  endfunction

  task automatic drive_write(input int idx, input logic [31:0] d);
    wen   = 1'b1;
    waddr = DL2'(idx);
    wdata = d;
    ref_mem[idx] = d;
  endtask

  // One full fetch: handshake, latency, optional collision write on the sample
  // cycle, stall with rready low, then completion.
  task automatic do_read(input logic [31:0] a, input int stall, input bit collide,
                         input int cidx, input logic [31:0] cdata, input bit noise);
    int n;
    bit seen;
    logic [31:0] exp_d;
    logic [2:0]  exp_r;
    arvalid = 1'b1;
    araddr  = a;
    rready  = 1'b0;
    wen     = 1'b0;
    seen    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (arready) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("ar_accept", 32'(seen), 32'd1);
    if (!seen) begin
      arvalid = 1'b0;
      return;
    end
    exp_r = model_resp(a);
    exp_d = model_data(a);
    n = 0;
    forever begin
      step();
      n++;
      wen     = 1'b0;
      arvalid = noise ? 1'($urandom % 2) : 1'b0;
      araddr  = $urandom;
      if (rvalid || n >= 300) break;
      chk("ar_busy", 32'(arready), 32'd0);
      if (n == LAT) begin
        exp_r = model_resp(a);
        exp_d = model_data(a);
        if (collide) drive_write(cidx, cdata);
      end else if (noise && ($urandom % 3 == 0)) begin
        drive_write(int'($urandom % WORDS), $urandom);
      end
    end
    chk("r_latency", 32'(n), 32'(LAT + 1));
    chk("r_data", rdata, exp_d);
    chk("r_resp", 32'(rresp), 32'(exp_r));
    chk("ar_low_rvalid", 32'(arready), 32'd0);
    for (int k = 0; k < stall; k++) begin
      step();
      wen     = 1'b0;
      arvalid = noise ? 1'($urandom % 2) : 1'b0;
      araddr  = $urandom;
      chk("hold_rvalid", 32'(rvalid), 32'd1);
      chk("hold_rdata", rdata, exp_d);
      chk("hold_rresp", 32'(rresp), 32'(exp_r));
      chk("hold_arready", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    step();
    rready  = 1'b0;
    arvalid = 1'b0;
    wen     = 1'b0;
    chk("done_rvalid", 32'(rvalid), 32'd0);
    chk("done_arready", 32'(arready), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] edges [6];
    edges[0] = BASE - 32'd4;
    edges[1] = BASE - 32'd1;
    edges[2] = BASE + 32'd4092;
    edges[3] = BASE + 32'd4093;
    edges[4] = BASE + 32'd4096;
    edges[5] = BASE;
    case ($urandom % 6)
      0, 1:    return BASE + 32'(4 * ($urandom % WORDS));
      2:       return BASE + 32'($urandom % 4096);
      3:       return $urandom;
      4:       return edges[$urandom % 6];
      default: return BASE + 32'(4 * ($urandom % WORDS)) + 32'($urandom % 4);
    endcase
  endfunction

  initial begin
    int hs;
    int last;
    int overlap;
    int n;
    rst_n   = 1'b0;
    arvalid = 1'b0;
    araddr  = '0;
    rready  = 1'b0;
    wen     = 1'b0;
    waddr   = '0;
    wdata   = '0;
    step();
    step();
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);

    // Preload the whole array while reset is still asserted.
    for (int i = 0; i < WORDS; i++) begin
      drive_write(i, $urandom);
      step();
    end
    drive_write(0, 32'h0000_0413);
    step();
    drive_write(4, 32'h0010_0093);
    step();
    wen   = 1'b0;
    rst_n = 1'b1;
    step();

    do_read(BASE, 0, 1'b0, 0, 32'h0, 1'b0);
    do_read(BASE + 32'd8, 3, 1'b0, 0, 32'h0, 1'b0);
    do_read(32'h8000_1000, 0, 1'b0, 0, 32'h0, 1'b0);
    do_read(32'h8000_0002, 1, 1'b0, 0, 32'h0, 1'b0);
    do_read(32'h7FFF_FFFC, 0, 1'b0, 0, 32'h0, 1'b0);
    do_read(32'h8000_0010, 0, 1'b1, 4, 32'hDEAD_BEEF, 1'b0);
    do_read(32'h8000_0010, 0, 1'b0, 0, 32'h0, 1'b0);
    chk("collide_model", ref_mem[4], 32'hDEAD_BEEF);

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      a = rand_addr();
      do_read(a, int'($urandom % 4), 1'($urandom % 2), int'($urandom % 8), $urandom, 1'b1);
    end

    // Back-to-back fetches with arvalid and rready held high.
    arvalid = 1'b1;
    araddr  = BASE + 32'd8;
    rready  = 1'b1;
    hs      = 0;
    last    = -1;
    overlap = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (arready && rvalid) overlap++;
      if (arvalid && arready) begin
        if (last >= 0) chk("tp_gap", 32'(cyc - last), 32'(LAT + 2));
        last = cyc;
        hs++;
      end
      if (rvalid) chk("tp_data", rdata, ref_mem[2]);
      step();
    end
    chk("tp_count", 32'(hs), 32'd5);
    chk("tp_overlap", 32'(overlap), 32'd0);
    arvalid = 1'b0;
    for (int i = 0; i < LAT + 3; i++) step();
    rready = 1'b0;

    // Reset in the middle of the latency wait.
    arvalid = 1'b1;
    araddr  = BASE + 32'd12;
    n = 0;
    while (!arready && n < 8) begin
      step();
      n++;
    end
    step();
    arvalid = 1'b0;
    rst_n   = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_w_rvalid", 32'(rvalid), 32'd0);
    chk("abort_w_arready", 32'(arready), 32'd1);
    n = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      step();
      if (rvalid) n++;
    end
    chk("abort_w_quiet", 32'(n), 32'd0);

    // Reset while a response is being held.
    arvalid = 1'b1;
    araddr  = BASE + 32'd16;
    step();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      step();
      n++;
    end
    chk("abort_r_seen", 32'(rvalid), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_r_rvalid", 32'(rvalid), 32'd0);
    chk("abort_r_rdata", rdata, 32'd0);
    chk("abort_r_arready", 32'(arready), 32'd1);
    n = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      step();
      if (rvalid) n++;
    end
    chk("abort_r_quiet", 32'(n), 32'd0);

    // Contents survive the resets above.
    do_read(BASE, 0, 1'b0, 0, 32'h0, 1'b0);
    do_read(BASE + 32'd4092, 2, 1'b0, 0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
